// File: rtl/sdrc_app_arb.sv
// Round-robin arbiter sharing the sdrc_core application port among NREQ requesters.
// One transfer outstanding at a time; the grant is held until the burst's last beat.
module sdrc_app_arb #(
  parameter int NREQ   = 4,
  parameter int GW     = 2,
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_resetn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*APP_AW-1:0] req_addr,
  input  logic [NREQ*bl-1:0]     req_len,
  input  logic [NREQ-1:0]        req_wr_n,
  input  logic [NREQ*dw-1:0]     req_wr_data,
  input  logic [NREQ*dw/8-1:0]   req_wr_en_n,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        req_wr_next,
  output logic [NREQ-1:0]        req_rd_valid,
  output logic [NREQ-1:0]        req_last_rd,
  output logic [dw-1:0]          req_rd_data,
  output logic                   app_req,
  output logic [APP_AW-1:0]      app_req_addr,
  output logic [bl-1:0]          app_req_len,
  output logic                   app_req_wr_n,
  input  logic                   app_req_ack,
  output logic [dw-1:0]          app_wr_data,
  output logic [dw/8-1:0]        app_wr_en_n,
  input  logic                   app_wr_next_req,
  input  logic                   app_last_wr,
  input  logic                   app_rd_valid,
  input  logic                   app_last_rd,
  input  logic [dw-1:0]          app_rd_data,
  output logic [GW-1:0]          grant_id,
  output logic                   arb_busy
);

  localparam int BW = dw / 8;

  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  state_t            r_state;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant;
  logic              r_app_req;
  logic [APP_AW-1:0] r_app_req_addr;
  logic [bl-1:0]     r_app_req_len;
  logic              r_app_req_wr_n;

  logic              w_found;
  logic [GW-1:0]     w_sel;
  logic [NREQ-1:0]   w_onehot;
  logic              w_data_phase;
  logic              w_wr_done;

  // Search rr_ptr+1 .. rr_ptr+NREQ; iterating downwards lets the nearest hit win.
  always_comb begin
    logic [GW:0] idx;
    w_found = 1'b0;
    w_sel   = '0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (idx >= (GW+1)'(NREQ)) idx = idx - (GW+1)'(NREQ);
      if (req_valid[idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[GW-1:0];
      end
    end
  end

  assign w_wr_done = app_wr_next_req && app_last_wr;

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state        <= IDLE;
      r_rr_ptr       <= GW'(NREQ - 1);
      r_grant        <= '0;
      r_app_req      <= 1'b0;
      r_app_req_addr <= '0;
      r_app_req_len  <= '0;
      r_app_req_wr_n <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_app_req_addr <= req_addr[int'(w_sel)*APP_AW +: APP_AW];
            r_app_req_len  <= req_len[int'(w_sel)*bl +: bl];
            r_app_req_wr_n <= req_wr_n[w_sel];
            r_grant        <= w_sel;
            r_rr_ptr       <= w_sel;
            r_app_req      <= 1'b1;
            r_state        <= CMD;
          end
        end
        CMD: begin
          if (app_req_ack) begin
            r_app_req <= 1'b0;
            if (r_app_req_wr_n)  r_state <= RD;
            else if (w_wr_done)  r_state <= IDLE;
            else                 r_state <= WR;
          end
        end
        WR: if (w_wr_done) r_state <= IDLE;
        RD: if (app_rd_valid && app_last_rd) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_onehot     = NREQ'(1) << r_grant;
  assign w_data_phase = (r_state == CMD) || (r_state == WR);

  // A write beat may be consumed in the same cycle the command is accepted.
  assign req_ack      = (r_state == CMD && app_req_ack) ? w_onehot : '0;
  assign req_wr_next  = (app_wr_next_req && ((r_state == WR) ||
                        (r_state == CMD && app_req_ack && !r_app_req_wr_n))) ? w_onehot : '0;
  assign req_rd_valid = (r_state == RD && app_rd_valid) ? w_onehot : '0;
  assign req_last_rd  = (r_state == RD && app_last_rd)  ? w_onehot : '0;
  assign req_rd_data  = app_rd_data;

  assign app_wr_data  = w_data_phase ? req_wr_data[int'(r_grant)*dw +: dw] : '0;
  assign app_wr_en_n  = w_data_phase ? req_wr_en_n[int'(r_grant)*BW +: BW] : '1;

  assign app_req      = r_app_req;
  assign app_req_addr = r_app_req_addr;
  assign app_req_len  = r_app_req_len;
  assign app_req_wr_n = r_app_req_wr_n;
  assign grant_id     = r_grant;
  assign arb_busy     = (r_state != IDLE);

endmodule

// File: doc/sdrc_app_arb.md
Name: sdrc_app_arb

Overview:
- Round-robin arbiter that shares the single sdrc_core application port among NREQ independent requesters, for example the wb2sdrc bridge plus DMA engines.
- Sits between the requesters and sdrc_core, in the sdram_clk domain.
- Latches one requester's command, drives the app_req handshake, and steers write data out and read data back for that requester.
- Holds the grant until the burst completes; only one transfer is outstanding at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GW, 2, grant index width; must satisfy 2**GW >= NREQ.
- APP_AW, 26, application address width.
- dw, 32, application data width.
- bl, 9, burst length field width.

Ports:
- sdram_clk  in  1  controller clock; all logic is rising-edge.
- sdram_resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_addr  in  NREQ*APP_AW  packed addresses; requester i occupies slice i.
- req_len  in  NREQ*bl  packed burst lengths.
- req_wr_n  in  NREQ  0 = write, 1 = read.
- req_wr_data  in  NREQ*dw  packed write data.
- req_wr_en_n  in  NREQ*dw/8  packed active-low byte enables.
- req_ack  out  NREQ  one-hot, one-cycle command-accepted pulse.
- req_wr_next  out  NREQ  one-hot: present the next write word.
- req_rd_valid  out  NREQ  one-hot read-data-valid.
- req_last_rd  out  NREQ  one-hot last read beat.
- req_rd_data  out  dw  read data, broadcast to all requesters.
- app_req, app_req_addr[APP_AW], app_req_len[bl], app_req_wr_n  out  command to sdrc_core.
- app_req_ack  in  1  command accepted.
- app_wr_data[dw], app_wr_en_n[dw/8]  out  write data and byte enables.
- app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd  in  core burst status.
- app_rd_data  in  dw  core read data.
- grant_id  out  GW  index of the current owner.
- arb_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE.
  - app_req = 0; app_req_addr, app_req_len, app_req_wr_n = 0.
  - app_wr_en_n = all ones.
  - req_* one-hot outputs = 0; grant_id = 0; arb_busy = 0.
  - rr_ptr = NREQ-1, so requester 0 has first priority.
- States are IDLE, CMD, WR, RD.
- IDLE:
  - If any req_valid is set, select the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register its addr, len and wr_n into app_req_*; set grant_id and rr_ptr to that index; go to CMD.
  - Latency: req_valid high at edge N gives app_req = 1 after edge N+1.
- CMD:
  - app_req = 1, with registered fields held stable.
  - On app_req_ack: pulse req_ack[grant_id] in the same cycle (combinational from app_req_ack); app_req = 0 from the next cycle.
  - Next state is WR if app_req_wr_n = 0, else RD.
  - A write whose app_wr_next_req and app_last_wr coincide with app_req_ack goes straight to IDLE.
- WR:
  - req_wr_next[grant_id] = app_wr_next_req, combinational.
  - Exit to IDLE on the cycle app_wr_next_req && app_last_wr.
- RD:
  - req_rd_valid[grant_id] = app_rd_valid; req_last_rd[grant_id] = app_last_rd.
  - Exit to IDLE on app_rd_valid && app_last_rd.
- Data steering:
  - app_wr_data and app_wr_en_n select the grant_id slice in CMD and WR; otherwise app_wr_en_n is all ones and app_wr_data is 0.
  - req_rd_data = app_rd_data always (broadcast).
- Requester protocol:
  - Fields must be held until req_ack.
  - Dropping req_valid after the grant does not cancel the latched command.
  - Non-owners see all one-hot outputs at 0.
- Fairness:
  - The requester granted at IDLE->CMD gets the lowest priority next time.
  - The back-to-back minimum gap is one IDLE cycle per transfer.
- Reset mid-burst forces IDLE immediately; no completion is reported to the owner.
- req_len is passed unchanged, including 0; completion is detected only by the last_* strobes.

Test Plan:
- Single write: requester 2 issues addr 0x0000100, len 4, wr_n 0.
  - app_req rises 1 cycle after req_valid.
  - req_ack[2] pulses with app_req_ack.
  - 4 req_wr_next[2] pulses, with app_wr_data = req 2's data.
  - IDLE follows the last_wr beat.
- Round-robin: all 4 req_valid held high with len 1 reads → grant order 0,1,2,3,0; each grant_id is stable through its burst.
- Read steering: requester 1 reads len 8 → exactly 8 req_rd_valid[1], req_last_rd[1] on the 8th, and zero req_rd_valid on the other bits.
- Collision: len 1 write with app_req_ack, app_wr_next_req and app_last_wr in the same cycle → return to IDLE the next cycle, and a pending requester is granted 1 cycle later.
- Reset mid-RD: assert sdram_resetn low during beat 3 of 8 → all outputs reach their reset values asynchronously and rr_ptr = NREQ-1; after release, requester 0 wins a simultaneous 0/3 request.
- Idle: no req_valid for 100 cycles → app_req = 0, app_wr_en_n = all ones, arb_busy = 0 throughout.
